// File: rtl/img_writer_if.sv
// ---------------------------------------------------------------------------
// img_writer_if
// Purpose : bundles the pixel stream handshake and the image RAM write port
//           used by img_writer.
// Signals :
//   s_valid  stream pixel valid              (source -> writer)
//   s_data   stream pixel, RGB444            (source -> writer)
//   s_ready  writer accepts a pixel          (writer -> source)
//   wr_en    RAM write strobe                (writer -> RAM)
//   wr_addr  RAM write address {y, x}        (writer -> RAM)
//   wr_data  RAM write data                  (writer -> RAM)
// Modports:
//   slave  : the img_writer side
//   master : the environment side (pixel source + RAM)
// ---------------------------------------------------------------------------
interface img_writer_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  s_valid;
    logic [11:0]           s_data;
    logic                  s_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [11:0]           wr_data;

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/img_writer.sv
// ---------------------------------------------------------------------------
// img_writer
// Purpose : write side of the sprite image memory read by draw_img. Takes a
//           raster-ordered RGB444 pixel stream and writes one
//           RECT_WIDTH x RECT_LENGTH image into the image RAM, using the
//           same address packing as the read side:
//           addr = {y[ADDR_WIDTH/2-1:0], x[ADDR_WIDTH/2-1:0]}.
// Ports   :
//   pclk      pixel clock, the only clock
//   rst       asynchronous, active-low reset
//   start     1-cycle request to begin loading one image (honoured in IDLE)
//   abort     cancel the load in progress
//   bus       img_writer_if.slave: s_valid/s_data/s_ready stream in,
//             wr_en/wr_addr/wr_data RAM write port out
//   busy      load in progress
//   done      1-cycle pulse, coincident with the final RAM write
//   checksum  (CHECKSUM_EN only) 16-bit sum of the accepted pixels
// Options :
//   CHECKSUM_EN  when defined, adds the checksum port and its accumulator.
// Parameters:
//   RECT_WIDTH   pixels per row
//   RECT_LENGTH  rows per image
//   ADDR_WIDTH   RAM address width; must be even and each half must be
//                wide enough for both RECT_WIDTH and RECT_LENGTH
// ---------------------------------------------------------------------------
module img_writer #(
    parameter int RECT_WIDTH  = 128,
    parameter int RECT_LENGTH = 128,
    parameter int ADDR_WIDTH  = 14
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    img_writer_if.slave bus,
    output logic        busy,
    output logic        done
`ifdef CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    localparam int HALF = ADDR_WIDTH / 2;

    localparam logic [HALF-1:0] X_LAST = HALF'(RECT_WIDTH - 1);
    localparam logic [HALF-1:0] Y_LAST = HALF'(RECT_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic [HALF-1:0]       x_q,       x_d;
    logic [HALF-1:0]       y_q,       y_d;
    logic                  wr_en_q,   wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]           wr_data_q, wr_data_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;

    logic accept;
    logic last_pixel;

    // Ready comes straight from the state register so the source sees it in
    // the same cycle; abort withdraws it so a beat offered alongside abort is
    // never consumed.
    assign bus.s_ready = (state_q == LOAD) && !abort;
    assign accept      = bus.s_valid && bus.s_ready;
    assign last_pixel  = (x_q == X_LAST) && (y_q == Y_LAST);

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Next-state logic for the load FSM, the raster counters and the
    // registered write port.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (last_pixel) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The write for a beat appears one clock after its handshake, using
        // the counter values that addressed that beat.
        if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {y_q, x_q};
            wr_data_d = bus.s_data;

            // y saturates on the last row so the counters never leave the
            // image even though the FSM stops accepting after the last pixel.
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q != Y_LAST) begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        // busy/done are registered copies of the next state so they line up
        // exactly with the state register.
        busy_d = (state_d == LOAD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    assign checksum = checksum_q;

    // Cleared when a load starts; the last beat lands together with the
    // DONE transition, so the sum is final in the DONE cycle and then holds
    // until the next start.
    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == IDLE) && start) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q + {4'h0, bus.s_data};
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end
`endif

endmodule

// File: tb/tb_img_writer.sv
// ---------------------------------------------------------------------------
// tb_img_writer
// Purpose : self-checking bench for img_writer with a 4x4 image and 4-bit
//           addresses. A beat-counting reference model predicts every
//           output each cycle; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_img_writer;

    localparam int W     = 4;
    localparam int L     = 4;
    localparam int AW    = 4;
    localparam int HALF  = AW / 2;
    localparam int TOTAL = W * L;

    logic        pclk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    img_writer_if #(.ADDR_WIDTH(AW)) bus_if ();

    img_writer #(
        .RECT_WIDTH (W),
        .RECT_LENGTH(L),
        .ADDR_WIDTH (AW)
    ) dut (
        .pclk    (pclk),
        .rst     (rst_n),
        .start   (start),
        .abort   (abort),
        .bus     (bus_if),
        .busy    (busy),
        .done    (done)
`ifdef CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

`ifndef CHECKSUM_EN
    assign checksum = 16'h0;
`endif

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int tests    = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Inputs change 2 time units after the rising edge and are held for one
    // full cycle.
    task automatic applyStimulus(input logic st, input logic ab, input logic v,
                                 input logic [11:0] d);
        start          = st;
        abort          = ab;
        bus_if.s_valid = v;
        bus_if.s_data  = d;
        @(posedge pclk);
        #2;
    endtask

    // ---------------- reference model ----------------
    // Tracks only "is a load running", "was the final pixel just taken" and
    // how many beats the current load has accepted; the address of beat n is
    // derived arithmetically from n.
    logic        m_loading;
    logic        m_done;
    int          m_count;
    logic        m_wr_en;
    logic [3:0]  m_wr_addr;
    logic [11:0] m_wr_data;
    logic [15:0] m_csum;
    wire         m_accept = m_loading && !abort && bus_if.s_valid;

    function automatic logic [3:0] addrOf(input int n);
        return 4'(((n / W) << HALF) | (n % W));
    endfunction

    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            m_loading <= 1'b0;
            m_done    <= 1'b0;
            m_count   <= 0;
            m_wr_en   <= 1'b0;
            m_wr_addr <= '0;
            m_wr_data <= '0;
            m_csum    <= '0;
        end else begin
            m_wr_en <= m_accept;
            m_done  <= 1'b0;
            if (m_accept) begin
                m_wr_addr <= addrOf(m_count);
                m_wr_data <= bus_if.s_data;
                m_count   <= m_count + 1;
                m_csum    <= m_csum + {4'h0, bus_if.s_data};
            end
            if (!m_loading && !m_done && start) begin
                m_loading <= 1'b1;
                m_count   <= 0;
                m_csum    <= '0;
            end else if (m_loading && abort) begin
                m_loading <= 1'b0;
            end else if (m_accept && m_count == TOTAL - 1) begin
                m_loading <= 1'b0;
                m_done    <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic cmp_en = 1'b0;

    always @(negedge pclk) begin
        if (cmp_en) begin
            checkOutput("s_ready", 32'(bus_if.s_ready), 32'(m_loading && !abort));
            checkOutput("wr_en",   32'(bus_if.wr_en),   32'(m_wr_en));
            checkOutput("wr_addr", 32'(bus_if.wr_addr), 32'(m_wr_addr));
            checkOutput("wr_data", 32'(bus_if.wr_data), 32'(m_wr_data));
            checkOutput("busy",    32'(busy),           32'(m_loading));
            checkOutput("done",    32'(done),           32'(m_done));
`ifdef CHECKSUM_EN
            checkOutput("checksum", 32'(checksum), 32'(m_csum));
`endif
        end
    end

    // ---------------- write / done log ----------------
    logic [3:0]  log_addr[$];
    logic [11:0] log_data[$];
    int          done_cnt       = 0;
    logic [3:0]  done_addr      = '0;
    logic        done_wr_en     = 1'b0;
    logic [15:0] done_checksum  = '0;

    always @(negedge pclk) begin
        if (rst_n) begin
            if (bus_if.wr_en) begin
                log_addr.push_back(bus_if.wr_addr);
                log_data.push_back(bus_if.wr_data);
            end
            if (done) begin
                done_cnt++;
                done_addr     = bus_if.wr_addr;
                done_wr_en    = bus_if.wr_en;
                done_checksum = checksum;
            end
        end
    end

    task automatic clearLog();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int beats;
        int bad;

        rst_n          = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        bus_if.s_valid = 1'b0;
        bus_if.s_data  = '0;
        #1;
        cmp_en = 1'b1;
        repeat (2) @(posedge pclk);
        #2;
        checkOutput("reset_outputs",
                    32'({bus_if.s_ready, bus_if.wr_en, busy, done, bus_if.wr_addr, bus_if.wr_data}),
                    32'h0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 12'h000);

        // Full load with s_valid held high; start is repeated during DONE.
        clearLog();
        applyStimulus(1, 0, 0, 12'h000);
        for (int i = 0; i < TOTAL; i++) begin
            applyStimulus(0, 0, 1, 12'(12'h100 + i));
        end
        applyStimulus(1, 0, 0, 12'h000);
        applyStimulus(0, 0, 0, 12'h000);
        applyStimulus(0, 0, 0, 12'h000);
        checkOutput("full_count", 32'(log_addr.size()), 32'd16);
        if (log_addr.size() == 16) begin
            checkOutput("first_addr",  32'(log_addr[0]),  32'h0);
            checkOutput("row_wrap",    32'(log_addr[4]),  32'b0100);
            checkOutput("last_addr",   32'(log_addr[15]), 32'hF);
            checkOutput("first_data",  32'(log_data[0]),  32'h100);
            checkOutput("last_data",   32'(log_data[15]), 32'h10F);
        end
        checkOutput("done_once",    32'(done_cnt),   32'd1);
        checkOutput("done_addr",    32'(done_addr),  32'hF);
        checkOutput("done_with_wr", 32'(done_wr_en), 32'd1);

        // Load with s_valid gaps: pattern 1,0,0.
        clearLog();
        applyStimulus(1, 0, 0, 12'h000);
        beats = 0;
        for (int c = 0; c < 60 && beats < TOTAL; c++) begin
            if (c % 3 == 0) begin
                applyStimulus(0, 0, 1, 12'(12'h200 + beats));
                beats++;
            end else begin
                applyStimulus(0, 0, 0, 12'hEEE);
            end
        end
        applyStimulus(0, 0, 0, 12'h000);
        applyStimulus(0, 0, 0, 12'h000);
        checkOutput("gap_count", 32'(log_addr.size()), 32'd16);
        bad = 0;
        foreach (log_addr[i]) begin
            if (log_addr[i] != 4'(i) || log_data[i] != 12'(12'h200 + i)) bad++;
        end
        checkOutput("gap_contiguous", 32'(bad), 32'd0);
        checkOutput("gap_done_once",  32'(done_cnt), 32'd1);

        // Abort after 6 beats, with a beat offered in the abort cycle.
        clearLog();
        applyStimulus(1, 0, 0, 12'h000);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 1, 12'(12'h300 + i));
        end
        applyStimulus(0, 1, 1, 12'h3FF);
        applyStimulus(0, 0, 0, 12'h000);
        applyStimulus(0, 0, 0, 12'h000);
        checkOutput("abort_count",   32'(log_addr.size()), 32'd6);
        if (log_addr.size() == 6) begin
            checkOutput("abort_last", 32'(log_addr[5]), 32'h5);
        end
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
        checkOutput("abort_busy",    32'(busy),     32'd0);

        // Restart after abort, then reset in the middle of the load.
        clearLog();
        applyStimulus(1, 0, 0, 12'h000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 12'(12'h400 + i));
        end
        if (log_addr.size() >= 1) begin
            checkOutput("restart_addr0", 32'(log_addr[0]), 32'h0);
            checkOutput("restart_data0", 32'(log_data[0]), 32'h400);
        end else begin
            checkOutput("restart_count", 32'(log_addr.size()), 32'd3);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midload_reset",
                    32'({bus_if.s_ready, bus_if.wr_en, busy, done, bus_if.wr_addr, bus_if.wr_data}),
                    32'h0);
        @(posedge pclk);
        #2;
        clearLog();
        rst_n = 1'b1;

        // s_valid without start: nothing accepted, nothing written.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 12'hABC);
        end
        applyStimulus(0, 0, 0, 12'h000);
        checkOutput("nostart_writes", 32'(log_addr.size()), 32'd0);
        checkOutput("reset_no_done",  32'(done_cnt),        32'd0);

`ifdef CHECKSUM_EN
        clearLog();
        applyStimulus(1, 0, 0, 12'h000);
        for (int i = 0; i < TOTAL; i++) begin
            applyStimulus(0, 0, 1, 12'hFFF);
        end
        applyStimulus(0, 0, 0, 12'h000);
        checkOutput("csum_at_done", 32'(done_checksum), 32'hFFF0);
        checkOutput("csum_held",    32'(checksum),      32'hFFF0);
        applyStimulus(1, 0, 0, 12'h000);
        checkOutput("csum_cleared", 32'(checksum),      32'h0);
        applyStimulus(0, 1, 0, 12'h000);
        applyStimulus(0, 0, 0, 12'h000);
`endif

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
